stream_arbiter: RTL and testbench
=================================

# stream_arbiter

Round-robin arbiter that shares one valid/ready byte-stream sink (the `stream_in_*` side of the sample design) between `NUM_REQ` requesters. It grants one requester at a time for a bounded burst, forwards the accepted beats through a single-entry output register, and tags each beat with the source index. It sits between the per-source drivers and the shared stream input.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: beat width in bits.
- `MAX_BURST`, 4: maximum beats per grant, 1..15.
- `ID_W`, derived: `$clog2(NUM_REQ)`; not overridable.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `out_valid`  out  1  output beat valid (registered).
- `out_data`  out  DATA_WIDTH  output beat (registered).
- `out_id`  out  ID_W  source index of the output beat (registered).
- `out_ready`  in  1  sink accept.
- `busy`  out  1  high while in GRANT (registered).

## Operation
- A transfer happens on a requester in any cycle where `req_valid[k] && req_ready[k]`. An output transfer happens in any cycle where `out_valid && out_ready`.
- The FSM has two states, IDLE and GRANT. It also holds `grant_idx` (ID_W bits), `rr_ptr` (ID_W bits) and `beat_cnt` (4 bits).
- **IDLE:**
  - `req_ready` = 0.
  - If any `req_valid` is set, pick the first set bit scanning upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Load that index into `grant_idx`, clear `beat_cnt`, and go to GRANT.
  - If no `req_valid` is set, stay in IDLE.
- **GRANT:**
  - `req_ready[grant_idx] = !out_valid || out_ready`; all other `req_ready` bits are 0.
  - On a transfer, load the output register from `req_data[grant_idx]`, set `out_id = grant_idx`, and increment `beat_cnt`.
  - Go to IDLE and set `rr_ptr = (grant_idx+1) mod NUM_REQ` when either:
    - a transfer occurs with `beat_cnt+1 == MAX_BURST`, or
    - `req_valid[grant_idx]` is 0 in this cycle (early release).
- **Output register:**
  - Set `out_valid` on a transfer.
  - Clear `out_valid` on an output transfer when there is no simultaneous input transfer.
  - When both happen in the same cycle, `out_valid` stays 1 and the register holds the new beat.
  - `out_data` and `out_id` change only on a transfer.
- **Reset values:** all outputs are 0 (`req_ready`, `out_valid`, `out_data`, `out_id`, `busy`). State is IDLE, `rr_ptr` = 0, `grant_idx` = 0, `beat_cnt` = 0.
- **Boundary conditions:**
  - A single active requester still loses the grant after MAX_BURST beats. It re-wins after one IDLE cycle.
  - With `out_ready` low and `out_valid` high, `req_ready` stays low. The grant is held and `beat_cnt` does not advance; there is no timeout.
  - Requests that arrive mid-burst wait for release. Fairness is strictly round-robin from `rr_ptr`.
  - Reset asserted mid-burst discards the beat in the output register (`out_valid` = 0 the cycle after reset is sampled). No partial burst resumes.
  - `req_data` of non-granted requesters is ignored.

## Timing
- **Arbitration:** one IDLE cycle. A `req_valid` first sampled in IDLE at edge N gives `req_ready` high in cycle N+1, so the earliest accept is at edge N+1.
- **Latency:** one cycle from an accepted requester beat to `out_valid`/`out_data`.
- **Throughput:** one beat per cycle within a burst while `out_ready` = 1. There is exactly one idle cycle between consecutive grants.
- **Combinational paths:** `req_ready` depends combinationally on `out_ready` (single-entry pipe). No other combinational input-to-output path exists.
- **Cycle accounting:** `busy` is high in every GRANT cycle, including the cycle in which release is decided.

## Test plan
- **Reset:** hold `reset_n` = 0 for 3 cycles with all `req_valid` = 1 → all outputs 0 throughout. First grant goes to requester 0 two edges after release.
- **Single requester:** requester 2 streams 0x10..0x17 continuously with `out_ready` = 1 → output 0x10..0x13 with `out_id` = 2, one bubble, then 0x14..0x17.
- **Round-robin rotation:** all 4 requesters valid, each sending its own index ×0x11 → bursts appear in order id 0,1,2,3,0, 4 beats each, one gap cycle between bursts.
- **Backpressure:** `out_ready` = 0 for 5 cycles mid-burst → `req_ready` low, `out_data` stable, no beat lost or duplicated. Burst completes at exactly 4 beats.
- **Early release:** requester 1 drops `req_valid` after 2 beats while requester 3 is pending → grant moves to 3 after one IDLE cycle, and `rr_ptr` becomes 2.
- **Reset mid-burst:** assert `reset_n` = 0 after beat 2 with `out_valid` = 1 → `out_valid` = 0 next cycle. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/stream_arbiter_if.sv
// Shared stream bus between the requesters, the round-robin arbiter and the sink.
// The arbiter attaches through the master modport; the environment uses slave.
interface stream_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_W-1:0]               out_id;
    logic                          out_ready;
    logic                          busy;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin burst arbiter: shares one valid/ready sink between NUM_REQ sources,
// forwarding accepted beats through a single-entry output register tagged with the source index.
//
// state   | meaning
// S_IDLE  | no grant; pick next requester scanning up from r_rr_ptr
// S_GRANT | r_grant_idx owns the sink for up to MAX_BURST beats
module stream_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    stream_arbiter_if.master io_stream
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_W   = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX    = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]      MAX_BURST_W = 4'(MAX_BURST);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_grant_idx;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [3:0]            r_beat_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ID_W-1:0]       r_out_id;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [ID_W-1:0]       w_grant_nxt;
    logic [ID_W-1:0]       w_rr_nxt;
    logic [3:0]            w_beat_nxt;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic                  w_can_accept;
    logic                  w_xfer;
    logic                  w_found;
    logic [ID_W-1:0]       w_pick;
    logic [ID_W:0]         w_cand;
    logic [ID_W-1:0]       w_grant_inc;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // First valid requester at or above r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_cand >= NUM_REQ_W) begin
                w_cand = w_cand - NUM_REQ_W;
            end
            if (!w_found && io_stream.req_valid[w_cand[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant_idx == ID_W'(k)) begin
                w_sel_data = io_stream.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_grant_inc  = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + ID_W'(1);
    assign w_can_accept = !r_out_valid || io_stream.out_ready;
    assign w_xfer       = (r_state == S_GRANT) && io_stream.req_valid[r_grant_idx] && w_can_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_pick;
                    w_beat_nxt  = '0;
                end
            end
            S_GRANT: begin
                w_req_ready[r_grant_idx] = w_can_accept;
                if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + 4'd1;
                end
                // A stalled sink holds the grant indefinitely; only burst end or a dropped valid releases it.
                if ((w_xfer && (r_beat_cnt + 4'd1 == MAX_BURST_W)) || !io_stream.req_valid[r_grant_idx]) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_grant_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_busy      <= (w_state_nxt == S_GRANT);
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_id    <= r_grant_idx;
            end else if (r_out_valid && io_stream.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_stream.req_ready = w_req_ready;
    assign io_stream.out_valid = r_out_valid;
    assign io_stream.out_data  = r_out_data;
    assign io_stream.out_id    = r_out_id;
    assign io_stream.busy      = r_busy;
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: per-source beat queues feed the requesters, a monitor
// logs sink transfers, and each scenario compares that log against hand-written expectations.
module tb_stream_arbiter;
    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [7:0] src_q [4][$];
    logic [3:0] src_en;
    logic [7:0] obs_data [$];
    logic [1:0] obs_id   [$];
    int         obs_cyc  [$];
    logic [7:0] exp_data [$];
    logic [1:0] exp_id   [$];

    stream_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) u_if ();

    stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .io_stream (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    // Requester model and sink monitor: drive on the falling edge, sample the handshakes 1 ns later.
    initial begin
        u_if.req_valid = '0;
        u_if.req_data  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                u_if.req_valid[k] = src_en[k] && (src_q[k].size() > 0);
                u_if.req_data[k*8 +: 8] = (src_q[k].size() > 0) ? src_q[k][0] : 8'hEE;
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                if (u_if.req_valid[k] && u_if.req_ready[k]) void'(src_q[k].pop_front());
            end
            if (u_if.out_valid && u_if.out_ready) begin
                obs_data.push_back(u_if.out_data);
                obs_id.push_back(u_if.out_id);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_pos();
        @(posedge clk);
        #3;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic fill_src(input int k, input logic [7:0] d0, input int n, input bit incr);
        for (int i = 0; i < n; i++) src_q[k].push_back(incr ? d0 + 8'(i) : d0);
    endtask

    task automatic add_exp(input logic [1:0] id, input logic [7:0] d0, input int n, input bit incr);
        for (int i = 0; i < n; i++) begin
            exp_id.push_back(id);
            exp_data.push_back(incr ? d0 + 8'(i) : d0);
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 4; k++) src_q[k].delete();
        obs_data.delete();
        obs_id.delete();
        obs_cyc.delete();
        exp_data.delete();
        exp_id.delete();
    endtask

    // Leaves the bench at posedge+3 with reset still asserted and all queues empty.
    task automatic do_reset();
        reset_n = 1'b0;
        tick_pos();
        tick_pos();
        clear_logs();
        src_en         = 4'hF;
        u_if.out_ready = 1'b1;
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 300 && obs_data.size() < n; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
    endtask

    task automatic compare_obs(input string name);
        chk_eq({name, "_count"}, obs_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            chk_eq($sformatf("%s_data%0d", name, i), obs_data[i], exp_data[i]);
            chk_eq($sformatf("%s_id%0d", name, i), obs_id[i], exp_id[i]);
        end
    endtask

    function automatic int gap(input int i);
        if (i >= obs_cyc.size() || i < 1) return -1;
        return obs_cyc[i] - obs_cyc[i-1];
    endfunction

    initial begin
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        src_en = 4'hF;
        reset_n = 1'b0;
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) fill_src(k, 8'(k * 8'h11), 4, 1'b0);

        // Reset held with every requester valid
        @(posedge clk);
        repeat (3) begin
            at_neg();
            chk_eq("rst_outputs", {u_if.req_ready, u_if.out_valid, u_if.out_data, u_if.out_id, u_if.busy}, 32'h0);
        end
        tick_pos();
        reset_n = 1'b1;
        tick_pos();
        at_neg();
        chk_eq("rst_first_grant_ready", u_if.req_ready, 32'h1);
        chk_eq("rst_first_grant_busy", u_if.busy, 32'h1);

        // Single requester streaming through two bursts
        do_reset();
        fill_src(2, 8'h10, 8, 1'b1);
        add_exp(2, 8'h10, 8, 1'b1);
        reset_n = 1'b1;
        wait_obs(8);
        compare_obs("single");
        chk_eq("single_inburst_span", obs_cyc.size() >= 4 ? obs_cyc[3] - obs_cyc[0] : -1, 32'd3);
        chk_eq("single_bubble", gap(4), 32'd2);

        // Round-robin rotation across all four requesters
        do_reset();
        fill_src(0, 8'h00, 8, 1'b0);
        fill_src(1, 8'h11, 4, 1'b0);
        fill_src(2, 8'h22, 4, 1'b0);
        fill_src(3, 8'h33, 4, 1'b0);
        add_exp(0, 8'h00, 4, 1'b0);
        add_exp(1, 8'h11, 4, 1'b0);
        add_exp(2, 8'h22, 4, 1'b0);
        add_exp(3, 8'h33, 4, 1'b0);
        add_exp(0, 8'h00, 4, 1'b0);
        reset_n = 1'b1;
        wait_obs(20);
        compare_obs("rr");
        for (int b = 1; b < 5; b++) chk_eq($sformatf("rr_gap%0d", b), gap(4 * b), 32'd2);

        // Backpressure for five cycles after the second accepted beat
        do_reset();
        fill_src(0, 8'hA0, 6, 1'b1);
        add_exp(0, 8'hA0, 6, 1'b1);
        reset_n = 1'b1;
        tick_pos();
        tick_pos();
        tick_pos();
        u_if.out_ready = 1'b0;
        repeat (5) begin
            at_neg();
            chk_eq("bp_req_ready", u_if.req_ready, 32'h0);
            chk_eq("bp_out_valid", u_if.out_valid, 32'h1);
            chk_eq("bp_out_data", u_if.out_data, 32'hA1);
            chk_eq("bp_busy", u_if.busy, 32'h1);
            tick_pos();
        end
        u_if.out_ready = 1'b1;
        wait_obs(6);
        compare_obs("bp");
        chk_eq("bp_tail_consecutive", gap(3), 32'd1);
        chk_eq("bp_burst_end_gap", gap(4), 32'd2);

        // Early release: requester 1 runs dry after two beats while 3 waits
        do_reset();
        fill_src(1, 8'h21, 2, 1'b1);
        fill_src(3, 8'h31, 4, 1'b1);
        add_exp(1, 8'h21, 2, 1'b1);
        add_exp(3, 8'h31, 4, 1'b1);
        reset_n = 1'b1;
        tick_pos();
        tick_pos();
        tick_pos();
        at_neg();
        chk_eq("er_busy_release_cycle", u_if.busy, 32'h1);
        tick_pos();
        at_neg();
        chk_eq("er_idle_busy", u_if.busy, 32'h0);
        chk_eq("er_idle_ready", u_if.req_ready, 32'h0);
        chk_eq("er_rr_ptr", dut.r_rr_ptr, 32'd2);
        tick_pos();
        at_neg();
        chk_eq("er_grant3_busy", u_if.busy, 32'h1);
        chk_eq("er_grant3_ready", u_if.req_ready, 32'h8);
        wait_obs(6);
        compare_obs("er");
        chk_eq("er_switch_gap", gap(2), 32'd3);

        // Reset asserted mid-burst with a beat held in the output register
        do_reset();
        fill_src(0, 8'h50, 8, 1'b1);
        fill_src(1, 8'h60, 4, 1'b1);
        reset_n = 1'b1;
        tick_pos();
        tick_pos();
        tick_pos();
        chk_eq("mr_pre_out_valid", u_if.out_valid, 32'h1);
        chk_eq("mr_pre_out_data", u_if.out_data, 32'h51);
        reset_n = 1'b0;
        tick_pos();
        chk_eq("mr_out_valid_dropped", u_if.out_valid, 32'h0);
        chk_eq("mr_busy_dropped", u_if.busy, 32'h0);
        chk_eq("mr_ready_dropped", u_if.req_ready, 32'h0);
        tick_pos();
        clear_logs();
        fill_src(0, 8'h58, 2, 1'b1);
        fill_src(1, 8'h68, 1, 1'b1);
        add_exp(0, 8'h58, 2, 1'b1);
        add_exp(1, 8'h68, 1, 1'b1);
        reset_n = 1'b1;
        tick_pos();
        at_neg();
        chk_eq("mr_restart_ready", u_if.req_ready, 32'h1);
        wait_obs(3);
        compare_obs("mr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
